// File: rtl/z80fi_insn_collector_pkg.sv
// Shared constants for the Z80FI instruction collector: default packet size,
// byte-count width and collector FSM state encodings.
package z80fi_insn_collector_pkg;

  // Default number of instruction bytes packed per packet.
  localparam int Z80FI_MAX_INSN_LEN = 4;

  // Byte count width; also the width of z80fi_insn_len (covers MAX_LEN up to 7).
  localparam int CNT_W = 3;

  // Collector FSM states.
  localparam logic [0:0] Z80FI_COL_IDLE    = 1'b0;
  localparam logic [0:0] Z80FI_COL_COLLECT = 1'b1;

endpackage

// File: rtl/z80fi_insn_collector_byte_packer.sv
// Slot-indexed byte packer. Byte k of an instruction lands at [8k+7:8k]; the
// count saturates at MAX_LEN and later bytes are dropped.
// wdata_o/wcnt_o expose the buffer with this cycle's write already merged, so
// the parent can emit a packet that includes a byte arriving with insn_done.
// clr_i starts a fresh buffer, optionally seeded with data_i in slot 0 (first_i).
// Optional port full_o exists only when Z80FI_INSN_ERR_EN is defined.
module z80fi_insn_collector_byte_packer
  import z80fi_insn_collector_pkg::*;
#(
  parameter int MAX_LEN = Z80FI_MAX_INSN_LEN
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clr_i,
  input  logic                 first_i,
  input  logic                 wr_i,
  input  logic [7:0]           data_i,
  output logic [8*MAX_LEN-1:0] wdata_o,
  output logic [CNT_W-1:0]     wcnt_o
`ifdef Z80FI_INSN_ERR_EN
  , output logic               full_o
`endif
);

  logic [8*MAX_LEN-1:0] data_q, data_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  // Merge this cycle's byte into the slot selected by the current count.
  always_comb begin
    wdata_o = data_q;
    wcnt_o  = cnt_q;
    if (wr_i && (cnt_q < CNT_W'(MAX_LEN))) begin
      for (int k = 0; k < MAX_LEN; k++) begin
        if (cnt_q == CNT_W'(k)) wdata_o[8*k +: 8] = data_i;
      end
      wcnt_o = cnt_q + 1'b1;
    end
  end

  // Next buffer: a fresh (optionally seeded) packet on clear, else the merged view.
  always_comb begin
    data_d = wdata_o;
    cnt_d  = wcnt_o;
    if (clr_i) begin
      data_d      = '0;
      data_d[7:0] = first_i ? data_i : 8'h00;
      cnt_d       = first_i ? CNT_W'(1) : '0;
    end
  end

  // Buffer and count registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

`ifdef Z80FI_INSN_ERR_EN
  assign full_o = (cnt_q == CNT_W'(MAX_LEN));
`endif

endmodule

// File: rtl/z80fi_insn_collector.sv
// Z80FI instruction collector: packs the bytes fetched for one instruction and
// presents them on the observation bus with a one-cycle z80fi_valid pulse one
// cycle after retirement. Optional fault flag under Z80FI_INSN_ERR_EN
// (overflow past MAX_LEN bytes, or a partial packet discarded by restart/flush).
module z80fi_insn_collector
  import z80fi_insn_collector_pkg::*;
#(
  parameter int MAX_LEN = Z80FI_MAX_INSN_LEN
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 m1_start,
  input  logic [15:0]          ip_in,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_data,
  input  logic                 insn_done,
  input  logic                 flush,
  output logic                 z80fi_valid,
  output logic [8*MAX_LEN-1:0] z80fi_insn,
  output logic [2:0]           z80fi_insn_len,
  output logic [15:0]          z80fi_reg_ip_in
`ifdef Z80FI_INSN_ERR_EN
  , output logic               z80fi_insn_err
`endif
);

  logic [0:0]           state_q, state_d;
  logic [15:0]          ip_q;
  logic                 collect;
  logic                 clr, first, wr, emit, cap_ip;
  logic [8*MAX_LEN-1:0] wdata, pkt_insn, insn_q;
  logic [CNT_W-1:0]     wcnt, pkt_len, len_q;
  logic [15:0]          pkt_ip, ip_out_q;
  logic                 valid_q;
`ifdef Z80FI_INSN_ERR_EN
  logic                 full, drop, discard, ovf_q, err_q;
`endif

  assign collect = (state_q == Z80FI_COL_COLLECT);

  z80fi_insn_collector_byte_packer #(.MAX_LEN(MAX_LEN)) u_packer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (clr),
    .first_i (first),
    .wr_i    (wr),
    .data_i  (byte_data),
    .wdata_o (wdata),
    .wcnt_o  (wcnt)
`ifdef Z80FI_INSN_ERR_EN
    , .full_o (full)
`endif
  );

  // FSM: flush beats everything; a done coincident with m1_start closes the old
  // packet (without the new byte) and seeds the next one with that byte.
  always_comb begin
    state_d  = state_q;
    clr      = 1'b0;
    first    = 1'b0;
    wr       = 1'b0;
    emit     = 1'b0;
    cap_ip   = 1'b0;
    pkt_insn = wdata;
    pkt_len  = wcnt;
    pkt_ip   = ip_q;
    if (flush) begin
      state_d = Z80FI_COL_IDLE;
      clr     = 1'b1;
    end else if (collect && insn_done) begin
      clr  = 1'b1;
      emit = (wcnt != '0);
      if (m1_start) begin
        state_d = Z80FI_COL_COLLECT;
        cap_ip  = 1'b1;
        first   = byte_valid;
      end else begin
        state_d = Z80FI_COL_IDLE;
        wr      = byte_valid;
      end
    end else if (m1_start) begin
      // Fresh start (from IDLE, or restart dropping a partial packet).
      clr           = 1'b1;
      cap_ip        = 1'b1;
      pkt_insn      = '0;
      pkt_insn[7:0] = byte_data;
      pkt_len       = byte_valid ? CNT_W'(1) : '0;
      pkt_ip        = ip_in;
      if (!collect && insn_done) begin
        // Single-cycle instruction: starts and retires together.
        emit    = byte_valid;
        state_d = Z80FI_COL_IDLE;
      end else begin
        state_d = Z80FI_COL_COLLECT;
        first   = byte_valid;
      end
    end else if (collect) begin
      wr = byte_valid;
    end
  end

  // State and captured instruction PC.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= Z80FI_COL_IDLE;
      ip_q    <= '0;
    end else begin
      state_q <= state_d;
      if (cap_ip) ip_q <= ip_in;
    end
  end

  // Registered observation outputs; packet fields hold until the next pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q  <= 1'b0;
      insn_q   <= '0;
      len_q    <= '0;
      ip_out_q <= '0;
    end else begin
      valid_q <= emit;
      if (emit) begin
        insn_q   <= pkt_insn;
        len_q    <= pkt_len;
        ip_out_q <= pkt_ip;
      end
    end
  end

  assign z80fi_valid     = valid_q;
  assign z80fi_insn      = insn_q;
  assign z80fi_insn_len  = len_q;
  assign z80fi_reg_ip_in = ip_out_q;

`ifdef Z80FI_INSN_ERR_EN
  assign drop    = wr & full;
  assign discard = collect & (flush | (m1_start & ~insn_done));

  // Sticky overflow per packet; error flags with the pulse or on a discard.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ovf_q <= clr ? 1'b0 : (ovf_q | drop);
      err_q <= (emit & (ovf_q | drop)) | discard;
    end
  end

  assign z80fi_insn_err = err_q;
`endif

endmodule

// File: tb/tb_z80fi_insn_collector.sv
// Directed table-driven bench for z80fi_insn_collector, plus a hand-written
// asynchronous-reset sequence. Error flag checks apply with Z80FI_INSN_ERR_EN.
module tb_z80fi_insn_collector;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m1_start, byte_valid, insn_done, flush;
  logic [15:0] ip_in;
  logic [7:0]  byte_data;
  logic        z80fi_valid;
  logic [31:0] z80fi_insn;
  logic [2:0]  z80fi_insn_len;
  logic [15:0] z80fi_reg_ip_in;
`ifdef Z80FI_INSN_ERR_EN
  logic        z80fi_insn_err;
`endif

  always #5 clk = ~clk;

  z80fi_insn_collector #(.MAX_LEN(4)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .m1_start        (m1_start),
    .ip_in           (ip_in),
    .byte_valid      (byte_valid),
    .byte_data       (byte_data),
    .insn_done       (insn_done),
    .flush           (flush),
    .z80fi_valid     (z80fi_valid),
    .z80fi_insn      (z80fi_insn),
    .z80fi_insn_len  (z80fi_insn_len),
    .z80fi_reg_ip_in (z80fi_reg_ip_in)
`ifdef Z80FI_INSN_ERR_EN
    , .z80fi_insn_err (z80fi_insn_err)
`endif
  );

  typedef struct {
    logic        m1;
    logic [15:0] ip;
    logic        bv;
    logic [7:0]  d;
    logic        done;
    logic        fl;
    logic        ev;
    logic [31:0] ei;
    logic [2:0]  el;
    logic [15:0] eip;
    logic        ee;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic m1, input logic [15:0] ip, input logic bv,
                       input logic [7:0] d, input logic done, input logic fl);
    m1_start   = m1;
    ip_in      = ip;
    byte_valid = bv;
    byte_data  = d;
    insn_done  = done;
    flush      = fl;
  endtask

  function automatic vec_t V(input logic m1, input logic [15:0] ip, input logic bv,
                             input logic [7:0] d, input logic done, input logic fl,
                             input logic ev, input logic [31:0] ei, input logic [2:0] el,
                             input logic [15:0] eip, input logic ee);
    vec_t v;
    v.m1 = m1; v.ip = ip; v.bv = bv; v.d = d; v.done = done; v.fl = fl;
    v.ev = ev; v.ei = ei; v.el = el; v.eip = eip; v.ee = ee;
    return v;
  endfunction

  initial begin
    // Rows: inputs for one cycle, outputs expected just after that edge.
    //                m1  ip       bv  d      dn fl   ev ei            el  eip      ee
    // LD (IX+5),n
    vq.push_back(V(1, 16'h1000, 1, 8'hDD, 0, 0,  0, 32'h0,        0, 16'h0,    0));
    vq.push_back(V(0, 16'h0,    1, 8'h36, 0, 0,  0, 32'h0,        0, 16'h0,    0));
    vq.push_back(V(0, 16'h0,    1, 8'h05, 0, 0,  0, 32'h0,        0, 16'h0,    0));
    vq.push_back(V(0, 16'h0,    1, 8'hAA, 1, 0,  1, 32'hAA0536DD, 4, 16'h1000, 0));
    vq.push_back(V(0, 16'h0,    0, 8'h00, 0, 0,  0, 32'hAA0536DD, 4, 16'h1000, 0));
    // NOP: start, byte and done in one cycle
    vq.push_back(V(1, 16'h0000, 1, 8'h00, 1, 0,  1, 32'h0,        1, 16'h0000, 0));
    vq.push_back(V(0, 16'h0,    0, 8'h00, 0, 0,  0, 32'h0,        1, 16'h0000, 0));
    // Back-to-back: LD A,42 then HALT
    vq.push_back(V(1, 16'h0000, 1, 8'h3E, 0, 0,  0, 32'h0,        1, 16'h0000, 0));
    vq.push_back(V(0, 16'h0,    1, 8'h42, 0, 0,  0, 32'h0,        1, 16'h0000, 0));
    vq.push_back(V(1, 16'h0002, 1, 8'h76, 1, 0,  1, 32'h0000423E, 2, 16'h0000, 0));
    vq.push_back(V(0, 16'h0,    0, 8'h00, 1, 0,  1, 32'h00000076, 1, 16'h0002, 0));
    vq.push_back(V(0, 16'h0,    0, 8'h00, 0, 0,  0, 32'h00000076, 1, 16'h0002, 0));
    // Overflow: five bytes offered
    vq.push_back(V(1, 16'h2000, 1, 8'hDD, 0, 0,  0, 32'h00000076, 1, 16'h0002, 0));
    vq.push_back(V(0, 16'h0,    1, 8'hCB, 0, 0,  0, 32'h00000076, 1, 16'h0002, 0));
    vq.push_back(V(0, 16'h0,    1, 8'h01, 0, 0,  0, 32'h00000076, 1, 16'h0002, 0));
    vq.push_back(V(0, 16'h0,    1, 8'h06, 0, 0,  0, 32'h00000076, 1, 16'h0002, 0));
    vq.push_back(V(0, 16'h0,    1, 8'hFF, 0, 0,  0, 32'h00000076, 1, 16'h0002, 0));
    vq.push_back(V(0, 16'h0,    0, 8'h00, 1, 0,  1, 32'h0601CBDD, 4, 16'h2000, 1));
    vq.push_back(V(0, 16'h0,    0, 8'h00, 0, 0,  0, 32'h0601CBDD, 4, 16'h2000, 0));
    // Flush after two bytes, then a stray done
    vq.push_back(V(1, 16'h3000, 1, 8'h11, 0, 0,  0, 32'h0601CBDD, 4, 16'h2000, 0));
    vq.push_back(V(0, 16'h0,    1, 8'h22, 0, 0,  0, 32'h0601CBDD, 4, 16'h2000, 0));
    vq.push_back(V(0, 16'h0,    0, 8'h00, 0, 1,  0, 32'h0601CBDD, 4, 16'h2000, 1));
    vq.push_back(V(0, 16'h0,    0, 8'h00, 1, 0,  0, 32'h0601CBDD, 4, 16'h2000, 0));
    // Restart mid-instruction discards the partial packet
    vq.push_back(V(1, 16'h4000, 1, 8'h01, 0, 0,  0, 32'h0601CBDD, 4, 16'h2000, 0));
    vq.push_back(V(1, 16'h4002, 1, 8'h02, 0, 0,  0, 32'h0601CBDD, 4, 16'h2000, 1));
    vq.push_back(V(0, 16'h0,    1, 8'h03, 1, 0,  1, 32'h00000302, 2, 16'h4002, 0));
    // Done with zero bytes collected is suppressed
    vq.push_back(V(1, 16'h5000, 0, 8'h00, 0, 0,  0, 32'h00000302, 2, 16'h4002, 0));
    vq.push_back(V(0, 16'h0,    0, 8'h00, 1, 0,  0, 32'h00000302, 2, 16'h4002, 0));
    vq.push_back(V(0, 16'h0,    0, 8'h00, 0, 0,  0, 32'h00000302, 2, 16'h4002, 0));
    // Byte in IDLE ignored, then a single-byte instruction
    vq.push_back(V(0, 16'h0,    1, 8'hEE, 0, 0,  0, 32'h00000302, 2, 16'h4002, 0));
    vq.push_back(V(1, 16'h6000, 1, 8'h12, 1, 0,  1, 32'h00000012, 1, 16'h6000, 0));
    // Flush wins over insn_done
    vq.push_back(V(1, 16'h7000, 1, 8'h55, 0, 0,  0, 32'h00000012, 1, 16'h6000, 0));
    vq.push_back(V(0, 16'h0,    1, 8'h66, 1, 1,  0, 32'h00000012, 1, 16'h6000, 1));

    // Reset state
    reset_n = 1'b0;
    drive(0, 16'h0, 0, 8'h00, 0, 0);
    #12;
    chk("reset valid", 32'(z80fi_valid), 32'h0);
    chk("reset insn",  z80fi_insn, 32'h0);
    chk("reset len",   32'(z80fi_insn_len), 32'h0);
    chk("reset ip",    32'(z80fi_reg_ip_in), 32'h0);
`ifdef Z80FI_INSN_ERR_EN
    chk("reset err",   32'(z80fi_insn_err), 32'h0);
`endif
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].m1, vq[i].ip, vq[i].bv, vq[i].d, vq[i].done, vq[i].fl);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d valid", i), 32'(z80fi_valid), 32'(vq[i].ev));
      chk($sformatf("row%0d insn", i),  z80fi_insn, vq[i].ei);
      chk($sformatf("row%0d len", i),   32'(z80fi_insn_len), 32'(vq[i].el));
      chk($sformatf("row%0d ip", i),    32'(z80fi_reg_ip_in), 32'(vq[i].eip));
`ifdef Z80FI_INSN_ERR_EN
      chk($sformatf("row%0d err", i),   32'(z80fi_insn_err), 32'(vq[i].ee));
`endif
    end

    // Asynchronous reset mid-instruction clears outputs without a clock edge.
    drive(1, 16'h8000, 1, 8'h77, 0, 0);
    @(posedge clk); #1;
    drive(0, 16'h0, 1, 8'h88, 0, 0);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("async valid", 32'(z80fi_valid), 32'h0);
    chk("async insn",  z80fi_insn, 32'h0);
    chk("async len",   32'(z80fi_insn_len), 32'h0);
    chk("async ip",    32'(z80fi_reg_ip_in), 32'h0);
    drive(0, 16'h0, 0, 8'h00, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    // Stray done after release must not produce a packet.
    drive(0, 16'h0, 0, 8'h00, 1, 0);
    @(posedge clk); #1;
    chk("post-reset done valid", 32'(z80fi_valid), 32'h0);
    drive(0, 16'h0, 0, 8'h00, 0, 0);
    @(posedge clk); #1;
    chk("post-reset valid", 32'(z80fi_valid), 32'h0);
    chk("post-reset len",   32'(z80fi_insn_len), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
